// File: rtl/event_capture_ctrl_if.sv
// Event capture controller bus: ADC/detector/readout handshakes and status.
interface event_capture_ctrl_if;
    localparam int unsigned CNT_W = 16;

    // Inputs to the controller
    logic             enable;
    logic             adc_count_valid;
    logic             event_detected;
    logic             ack;
    logic             clear_status;

    // Outputs from the controller
    logic             adc_start;
    logic             detector_reset;
    logic             capture_ready;
    logic             busy;
    logic [CNT_W-1:0] event_count;
    logic             missed_event;

    // Controller side
    modport master (
        input  enable,
        input  adc_count_valid,
        input  event_detected,
        input  ack,
        input  clear_status,
        output adc_start,
        output detector_reset,
        output capture_ready,
        output busy,
        output event_count,
        output missed_event
    );

    // Environment side (ADC front end, detector, readout)
    modport slave (
        output enable,
        output adc_count_valid,
        output event_detected,
        output ack,
        output clear_status,
        input  adc_start,
        input  detector_reset,
        input  capture_ready,
        input  busy,
        input  event_count,
        input  missed_event
    );
endinterface

// File: rtl/event_capture_ctrl.sv
// Event capture controller: paces ADC conversions, arms the event detector,
// collects a fixed number of post-event samples, then waits for readout ack
// and holds the detector in reset for a programmable holdoff period.
module event_capture_ctrl #(
    parameter int unsigned SAMPLE_DIVIDER = 100,
    parameter int unsigned POST_SAMPLES   = 16,
    parameter int unsigned HOLDOFF_CYCLES = 1000
) (
    input logic                  clock,
    input logic                  reset,
    event_capture_ctrl_if.master bus
);
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned POST_W = 8;
    localparam int unsigned HOLD_W = 16;
    localparam int unsigned CNT_W  = 16;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIVIDER - 1);
    localparam logic [POST_W-1:0] POST_LAST = POST_W'(POST_SAMPLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_POST     = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_HOLDOFF  = 3'd4
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [POST_W-1:0]   r_post_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_valid_q;
    logic                r_adc_start;
    logic                r_detector_reset;
    logic                r_capture_ready;
    logic                r_busy;
    logic [CNT_W-1:0]    r_event_count;
    logic                r_missed_event;

    logic                w_sample;
    logic                w_div_wrap;
    logic                w_accept;
    logic                w_missed_set;
    logic [POST_W-1:0]   w_post_inc;
    logic [CNT_W-1:0]    w_event_count_nxt;

    // Sample strobe, divider wrap, event acceptance and saturating count
    always_comb begin
        w_sample          = bus.adc_count_valid & ~r_valid_q;
        w_div_wrap        = (r_div_cnt == DIV_LAST);
        w_post_inc        = r_post_cnt + POST_W'(1);
        w_accept          = bus.enable & bus.event_detected & (r_state == ST_ARMED);
        w_missed_set      = bus.event_detected &
                            ((r_state == ST_POST) || (r_state == ST_WAIT_ACK) ||
                             (r_state == ST_HOLDOFF));
        w_event_count_nxt = r_event_count;
        if (w_accept && (r_event_count != CNT_MAX)) begin
            w_event_count_nxt = r_event_count + CNT_W'(1);
        end
    end

    // Control FSM, conversion divider, capture counters and status registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state          <= ST_IDLE;
            r_div_cnt        <= '0;
            r_post_cnt       <= '0;
            r_hold_cnt       <= '0;
            r_valid_q        <= 1'b0;
            r_adc_start      <= 1'b0;
            r_detector_reset <= 1'b1;
            r_capture_ready  <= 1'b0;
            r_busy           <= 1'b0;
            r_event_count    <= '0;
            r_missed_event   <= 1'b0;
        end else begin
            r_valid_q     <= bus.adc_count_valid;
            r_event_count <= w_event_count_nxt;

            // Sticky miss flag: a set in the same cycle beats a clear
            if (w_missed_set) begin
                r_missed_event <= 1'b1;
            end else if (bus.clear_status) begin
                r_missed_event <= 1'b0;
            end

            if (!bus.enable) begin
                // Disable drops straight back to IDLE from anywhere
                r_state          <= ST_IDLE;
                r_div_cnt        <= '0;
                r_post_cnt       <= '0;
                r_hold_cnt       <= '0;
                r_adc_start      <= 1'b0;
                r_detector_reset <= 1'b1;
                r_capture_ready  <= 1'b0;
                r_busy           <= 1'b0;
            end else begin
                // Divider runs in every enabled state except IDLE
                if (r_state == ST_IDLE) begin
                    r_div_cnt   <= '0;
                    r_adc_start <= 1'b0;
                end else begin
                    r_div_cnt   <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
                    r_adc_start <= w_div_wrap;
                end

                case (r_state)
                    ST_IDLE: begin
                        r_state          <= ST_ARMED;
                        r_detector_reset <= 1'b0;
                        r_busy           <= 1'b0;
                        r_capture_ready  <= 1'b0;
                    end
                    ST_ARMED: begin
                        if (bus.event_detected) begin
                            r_state    <= ST_POST;
                            r_post_cnt <= '0;
                            r_busy     <= 1'b1;
                        end
                    end
                    ST_POST: begin
                        if (w_sample) begin
                            r_post_cnt <= w_post_inc;
                            if (w_post_inc == POST_LAST) begin
                                r_state         <= ST_WAIT_ACK;
                                r_capture_ready <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (bus.ack) begin
                            r_state          <= ST_HOLDOFF;
                            r_capture_ready  <= 1'b0;
                            r_detector_reset <= 1'b1;
                            r_hold_cnt       <= '0;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_state          <= ST_ARMED;
                            r_detector_reset <= 1'b0;
                            r_busy           <= 1'b0;
                            r_hold_cnt       <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        end
                    end
                    default: begin
                        r_state          <= ST_IDLE;
                        r_detector_reset <= 1'b1;
                        r_capture_ready  <= 1'b0;
                        r_busy           <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Registered outputs onto the bus
    assign bus.adc_start      = r_adc_start;
    assign bus.detector_reset = r_detector_reset;
    assign bus.capture_ready  = r_capture_ready;
    assign bus.busy           = r_busy;
    assign bus.event_count    = r_event_count;
    assign bus.missed_event   = r_missed_event;

endmodule
